// File: rtl/cache_assoc_ctrl_if.sv
// CPU request port and main-memory line port of the set-associative cache.
// The cache uses the slave view; the CPU/memory side uses the master view.
interface cache_assoc_ctrl_if #(
    parameter int ADDR_W         = 32,
    parameter int WORDS_PER_LINE = 4
);
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_type;
    logic [ADDR_W-1:0]           address;
    logic [31:0]                 data_in;
    logic [31:0]                 dataOut;
    logic                        done_cache;
    logic                        hit;

    logic                        mem_req_valid;
    logic                        mem_req_write;
    logic [ADDR_W-1:0]           mem_addr;
    logic [32*WORDS_PER_LINE-1:0] mem_wdata;
    logic [32*WORDS_PER_LINE-1:0] mem_rdata;
    logic                        mem_ready;

    modport slave (
        input  req_valid, req_type, address, data_in, mem_rdata, mem_ready,
        output req_ready, dataOut, done_cache, hit,
               mem_req_valid, mem_req_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_type, address, data_in, mem_rdata, mem_ready,
        input  req_ready, dataOut, done_cache, hit,
               mem_req_valid, mem_req_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_assoc_ctrl.sv
// N-way set-associative write-back / write-allocate cache controller with
// round-robin replacement and saturating hit/miss counters.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | ready for a CPU request, captures it on req_valid
// S_LOOKUP    | tag compare; hit completes here, miss picks a victim way
// S_WRITEBACK | dirty victim line is written to memory
// S_REFILL    | requested line is read from memory into the victim way
// S_RESPOND   | read/write performed on the freshly filled line
module cache_assoc_ctrl #(
    parameter int NUM_SETS       = 64,
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    cache_assoc_ctrl_if.slave   bus,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);
    localparam int WORD_W = $clog2(WORDS_PER_LINE);
    localparam int OFS    = 2 + WORD_W;
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - OFS - IDX_W;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LINE_W = 32 * WORDS_PER_LINE;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND
    } state_t;

    state_t              state_q, state_d;
    logic                req_type_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [WAY_W-1:0]    victim_q;
    logic                refill_gap_q;

    logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data_mem [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];
    logic [WAY_W-1:0]    rr_q     [NUM_SETS];

    logic [WORD_W-1:0]   word_sel;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit_any, inv_any, victim_dirty, refill_done;
    logic [WAY_W-1:0]    hit_way, inv_way, victim, cur_way;
    logic [LINE_W-1:0]   cur_line;

    assign word_sel = addr_q[OFS-1:2];
    assign idx      = addr_q[OFS+IDX_W-1:OFS];
    assign req_tag  = addr_q[ADDR_W-1:OFS+IDX_W];

    // Descending scan so the lowest-numbered matching/invalid way wins.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_mem[idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        victim       = inv_any ? inv_way : rr_q[idx];
        victim_dirty = valid_q[idx][victim] && dirty_q[idx][victim];
        cur_way      = (state_q == S_LOOKUP) ? hit_way : victim_q;
        cur_line     = data_mem[idx][cur_way];
    end

    // The first REFILL cycle after a write-back keeps mem_req_valid low so
    // the memory sees the write-back request drop before the refill starts.
    assign refill_done = (state_q == S_REFILL) && bus.mem_ready && !refill_gap_q;

    always_comb begin
        state_d           = state_q;
        bus.req_ready     = 1'b0;
        bus.done_cache    = 1'b0;
        bus.hit           = 1'b0;
        bus.dataOut       = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_write = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    bus.done_cache = 1'b1;
                    bus.hit        = 1'b1;
                    bus.dataOut    = cur_line[word_sel*32 +: 32];
                    state_d        = S_IDLE;
                end else if (victim_dirty) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_WRITEBACK: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_write = 1'b1;
                bus.mem_addr      = {tag_mem[idx][victim_q], idx, {OFS{1'b0}}};
                bus.mem_wdata     = data_mem[idx][victim_q];
                if (bus.mem_ready) state_d = S_REFILL;
            end
            S_REFILL: begin
                bus.mem_req_valid = !refill_gap_q;
                bus.mem_addr      = {req_tag, idx, {OFS{1'b0}}};
                if (refill_done) state_d = S_RESPOND;
            end
            S_RESPOND: begin
                bus.done_cache = 1'b1;
                bus.dataOut    = cur_line[word_sel*32 +: 32];
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            req_type_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            victim_q     <= '0;
            refill_gap_q <= 1'b0;
            hit_count    <= '0;
            miss_count   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            refill_gap_q <= (state_q == S_WRITEBACK) && bus.mem_ready;
            if (state_q == S_IDLE && bus.req_valid) begin
                req_type_q <= bus.req_type;
                addr_q     <= bus.address;
                wdata_q    <= bus.data_in;
            end
            if (state_q == S_LOOKUP) begin
                if (hit_any) begin
                    if (hit_count != '1) hit_count <= hit_count + 1'b1;
                    if (req_type_q) dirty_q[idx][hit_way] <= 1'b1;
                end else begin
                    if (miss_count != '1) miss_count <= miss_count + 1'b1;
                    victim_q <= victim;
                    if (!inv_any && NUM_WAYS > 1) rr_q[idx] <= rr_q[idx] + 1'b1;
                end
            end
            if (refill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
            if (state_q == S_RESPOND && req_type_q) dirty_q[idx][victim_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOOKUP && hit_any && req_type_q)
            data_mem[idx][hit_way][word_sel*32 +: 32] <= wdata_q;
        if (refill_done) begin
            data_mem[idx][victim_q] <= bus.mem_rdata;
            tag_mem[idx][victim_q]  <= req_tag;
        end
        if (state_q == S_RESPOND && req_type_q)
            data_mem[idx][victim_q][word_sel*32 +: 32] <= wdata_q;
    end
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Directed bench for cache_assoc_ctrl: a 2-way default build and a 1-way build
// with 2-bit counters, served by a line-level memory model.
module tb_cache_assoc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_assoc_ctrl_if #(.ADDR_W(32), .WORDS_PER_LINE(4)) bus0 ();
    cache_assoc_ctrl_if #(.ADDR_W(32), .WORDS_PER_LINE(4)) bus1 ();

    logic [15:0] hit_cnt0, miss_cnt0;
    logic [1:0]  hit_cnt1, miss_cnt1;

    cache_assoc_ctrl #(.NUM_SETS(64), .NUM_WAYS(2), .WORDS_PER_LINE(4),
                       .ADDR_W(32), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .hit_count(hit_cnt0), .miss_count(miss_cnt0));

    cache_assoc_ctrl #(.NUM_SETS(64), .NUM_WAYS(1), .WORDS_PER_LINE(4),
                       .ADDR_W(32), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .hit_count(hit_cnt1), .miss_count(miss_cnt1));

    logic         req_valid_v[2], req_type_v[2], mem_ready_v[2];
    logic [31:0]  address_v[2], data_in_v[2];
    logic [127:0] mem_rdata_v[2];
    logic         req_ready_o[2], done_o[2], hit_o[2], mem_valid_o[2], mem_write_o[2];
    logic [31:0]  dout_o[2], mem_addr_o[2];
    logic [127:0] mem_wdata_o[2];

    assign bus0.req_valid = req_valid_v[0];
    assign bus0.req_type  = req_type_v[0];
    assign bus0.address   = address_v[0];
    assign bus0.data_in   = data_in_v[0];
    assign bus0.mem_rdata = mem_rdata_v[0];
    assign bus0.mem_ready = mem_ready_v[0];
    assign bus1.req_valid = req_valid_v[1];
    assign bus1.req_type  = req_type_v[1];
    assign bus1.address   = address_v[1];
    assign bus1.data_in   = data_in_v[1];
    assign bus1.mem_rdata = mem_rdata_v[1];
    assign bus1.mem_ready = mem_ready_v[1];

    assign req_ready_o[0] = bus0.req_ready;     assign req_ready_o[1] = bus1.req_ready;
    assign done_o[0]      = bus0.done_cache;    assign done_o[1]      = bus1.done_cache;
    assign hit_o[0]       = bus0.hit;           assign hit_o[1]       = bus1.hit;
    assign dout_o[0]      = bus0.dataOut;       assign dout_o[1]      = bus1.dataOut;
    assign mem_valid_o[0] = bus0.mem_req_valid; assign mem_valid_o[1] = bus1.mem_req_valid;
    assign mem_write_o[0] = bus0.mem_req_write; assign mem_write_o[1] = bus1.mem_req_write;
    assign mem_addr_o[0]  = bus0.mem_addr;      assign mem_addr_o[1]  = bus1.mem_addr;
    assign mem_wdata_o[0] = bus0.mem_wdata;     assign mem_wdata_o[1] = bus1.mem_wdata;

    typedef struct {
        logic        hit;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    logic [127:0] mstore [longint];
    logic [31:0]  golden [longint];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint mkey(input int sel, input logic [31:0] a);
        logic [63:0] k;
        k = {31'd0, sel[0], a};
        return longint'(k);
    endfunction

    // Initial memory image; line 0x1000 holds {D3,D2,D1,D0}.
    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a[31:4] == 28'h0000100) return 32'hD0 + {30'd0, a[3:2]};
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] mem_line(input int sel, input logic [31:0] la);
        logic [127:0] l;
        if (mstore.exists(mkey(sel, la))) return mstore[mkey(sel, la)];
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = pat(la + 32'(i * 4));
        return l;
    endfunction

    function automatic logic [31:0] gold_word(input int sel, input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (golden.exists(mkey(sel, wa))) return golden[mkey(sel, wa)];
        return pat(wa);
    endfunction

    // One CPU request, serving memory until done_cache; stall delays write-back ready.
    task automatic do_req(input int sel, input logic typ, input logic [31:0] a,
                          input logic [31:0] wd, input logic exp_hit, input int exp_wb,
                          input logic [31:0] exp_wb_addr, input logic [31:0] exp_wb_w2,
                          input int stall, input string tag);
        exp_t         e;
        exp_t         got;
        int           cyc, wb_n, rf_n, wait_n;
        logic         seen_done, in_req, stable, busy_ok;
        logic [31:0]  wb_addr, rf_addr, hold_addr;
        logic [127:0] wb_data, hold_wdata;

        e.hit      = exp_hit;
        e.chk_data = !typ;
        e.data     = gold_word(sel, a);
        sb.push_back(e);
        if (typ) golden[mkey(sel, {a[31:2], 2'b00})] = wd;

        @(negedge clk);
        check({tag, "/req_ready"}, 128'(req_ready_o[sel]), 128'd1);
        req_valid_v[sel] = 1'b1;
        req_type_v[sel]  = typ;
        address_v[sel]   = a;
        data_in_v[sel]   = wd;
        @(negedge clk);
        req_valid_v[sel] = 1'b0;

        cyc = 1; wb_n = 0; rf_n = 0; wait_n = 0;
        seen_done = 1'b0; in_req = 1'b0; stable = 1'b1; busy_ok = 1'b1;
        wb_addr = '0; rf_addr = '0; wb_data = '0; hold_addr = '0; hold_wdata = '0;
        while (!seen_done && cyc < 200) begin
            if (done_o[sel]) begin
                seen_done = 1'b1;
                check({tag, "/req_ready_vs_done"}, 128'(req_ready_o[sel]), 128'd0);
                check({tag, "/sb_nonempty"}, 128'(sb.size() > 0), 128'd1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check({tag, "/hit"}, 128'(hit_o[sel]), 128'(got.hit));
                    if (got.chk_data) check({tag, "/dataOut"}, 128'(dout_o[sel]), 128'(got.data));
                end
                if (exp_hit) check({tag, "/hit_latency"}, 128'(cyc), 128'd1);
            end else if (mem_valid_o[sel]) begin
                if (!in_req) begin
                    in_req     = 1'b1;
                    wait_n     = 0;
                    hold_addr  = mem_addr_o[sel];
                    hold_wdata = mem_wdata_o[sel];
                end else if (mem_addr_o[sel] !== hold_addr || mem_wdata_o[sel] !== hold_wdata) begin
                    stable = 1'b0;
                end
                if (req_ready_o[sel]) busy_ok = 1'b0;
                if (mem_write_o[sel] && wait_n < stall) begin
                    wait_n++;
                    req_valid_v[sel] = wait_n[0];
                    req_type_v[sel]  = 1'b1;
                    address_v[sel]   = 32'h0000_1000;
                    data_in_v[sel]   = 32'hBAD0_BAD0;
                end else begin
                    if (mem_write_o[sel]) begin
                        wb_n++;
                        wb_addr = hold_addr;
                        wb_data = hold_wdata;
                        mstore[mkey(sel, hold_addr)] = hold_wdata;
                    end else begin
                        rf_n++;
                        rf_addr = hold_addr;
                        mem_rdata_v[sel] = mem_line(sel, hold_addr);
                    end
                    mem_ready_v[sel] = 1'b1;
                    in_req = 1'b0;
                end
            end
            @(negedge clk);
            mem_ready_v[sel] = 1'b0;
            req_valid_v[sel] = 1'b0;
            req_type_v[sel]  = 1'b0;
            cyc++;
        end
        check({tag, "/done_seen"}, 128'(seen_done), 128'd1);
        check({tag, "/writebacks"}, 128'(wb_n), 128'(exp_wb));
        check({tag, "/refills"}, 128'(rf_n), exp_hit ? 128'd0 : 128'd1);
        if (!exp_hit) check({tag, "/refill_addr"}, 128'(rf_addr), 128'(a & 32'hFFFF_FFF0));
        if (exp_wb > 0) begin
            check({tag, "/wb_addr"}, 128'(wb_addr), 128'(exp_wb_addr));
            check({tag, "/wb_word2"}, 128'(wb_data[95:64]), 128'(exp_wb_w2));
        end
        if (stall > 0) begin
            check({tag, "/mem_stable"}, 128'(stable), 128'd1);
            check({tag, "/req_ready_busy"}, 128'(busy_ok), 128'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cyc;
        logic found;
        for (int i = 0; i < 2; i++) begin
            req_valid_v[i] = 1'b0; req_type_v[i] = 1'b0; mem_ready_v[i] = 1'b0;
            address_v[i] = '0; data_in_v[i] = '0; mem_rdata_v[i] = '0;
        end

        repeat (3) @(negedge clk);
        check("rst/req_ready", 128'(req_ready_o[0]), 128'd1);
        check("rst/done_cache", 128'(done_o[0]), 128'd0);
        check("rst/hit", 128'(hit_o[0]), 128'd0);
        check("rst/mem_req_valid", 128'(mem_valid_o[0]), 128'd0);
        check("rst/mem_req_write", 128'(mem_write_o[0]), 128'd0);
        check("rst/mem_addr", 128'(mem_addr_o[0]), 128'd0);
        check("rst/dataOut", 128'(dout_o[0]), 128'd0);
        check("rst/hit_count", 128'(hit_cnt0), 128'd0);
        check("rst/miss_count", 128'(miss_cnt0), 128'd0);
        rst = 1'b1;

        // 2-way build, set 0 holds 0x1000 / 0x2000 / 0x3000.
        do_req(0, 1'b0, 32'h0000_1004, 32'h0, 1'b0, 0, 32'h0, 32'h0, 0, "cold_rd_1004");
        @(negedge clk);
        check("cold/miss_count", 128'(miss_cnt0), 128'd1);
        do_req(0, 1'b0, 32'h0000_1004, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, "hit_rd_1004");
        @(negedge clk);
        check("hit/hit_count", 128'(hit_cnt0), 128'd1);
        do_req(0, 1'b1, 32'h0000_1008, 32'hCAFE_0000, 1'b1, 0, 32'h0, 32'h0, 0, "hit_wr_1008");
        do_req(0, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 0, 32'h0, 32'h0, 0, "fill_2000");
        do_req(0, 1'b0, 32'h0000_3000, 32'h0, 1'b0, 1, 32'h0000_1000, 32'hCAFE_0000, 20, "evict_3000");
        do_req(0, 1'b0, 32'h0000_1008, 32'h0, 1'b0, 0, 32'h0, 32'h0, 0, "rr_rd_1008");
        do_req(0, 1'b1, 32'h0000_4010, 32'h1234_5678, 1'b0, 0, 32'h0, 32'h0, 0, "wr_miss_4010");
        do_req(0, 1'b0, 32'h0000_4010, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, "rd_hit_4010");
        @(negedge clk);
        check("dut0/hit_count", 128'(hit_cnt0), 128'd3);
        check("dut0/miss_count", 128'(miss_cnt0), 128'd5);

        // 1-way build with 2-bit counters: clean-victim misses and saturation.
        do_req(1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 0, 32'h0, 32'h0, 0, "dm_rd_1000");
        do_req(1, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 0, 32'h0, 32'h0, 0, "dm_rd_2000");
        do_req(1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 0, 32'h0, 32'h0, 0, "dm_rd_1000b");
        @(negedge clk);
        check("dm/miss_count_3", 128'(miss_cnt1), 128'd3);
        do_req(1, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 0, 32'h0, 32'h0, 0, "dm_rd_2000b");
        @(negedge clk);
        check("dm/miss_count_sat", 128'(miss_cnt1), 128'd3);
        check("dm/hit_count", 128'(hit_cnt1), 128'd0);

        // Reset while the 2-way build is waiting in REFILL.
        @(negedge clk);
        req_valid_v[0] = 1'b1; req_type_v[0] = 1'b0; address_v[0] = 32'h0000_5000;
        @(negedge clk);
        req_valid_v[0] = 1'b0;
        found = 1'b0;
        wait_cyc = 0;
        while (!found && wait_cyc < 20) begin
            if (mem_valid_o[0] && !mem_write_o[0]) found = 1'b1;
            else begin
                @(negedge clk);
                wait_cyc++;
            end
        end
        check("rstmid/refill_seen", 128'(found), 128'd1);
        rst = 1'b0;
        #1;
        check("rstmid/mem_req_valid", 128'(mem_valid_o[0]), 128'd0);
        check("rstmid/req_ready", 128'(req_ready_o[0]), 128'd1);
        check("rstmid/hit_count", 128'(hit_cnt0), 128'd0);
        check("rstmid/miss_count", 128'(miss_cnt0), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        do_req(0, 1'b0, 32'h0000_1008, 32'h0, 1'b0, 0, 32'h0, 32'h0, 0, "post_rst_rd_1008");
        @(negedge clk);
        check("post_rst/miss_count", 128'(miss_cnt0), 128'd1);
        check("post_rst/hit_count", 128'(hit_cnt0), 128'd0);
        check("sb/empty", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_assoc_ctrl.md
Name: cache_assoc_ctrl

Overview:
Parametrised N-way set-associative write-back, write-allocate cache. It combines address decode, tag/valid/dirty storage, data storage, round-robin replacement and the miss-handling FSM in one block. It sits between the CPU request port and the main-memory line interface, and is the configurable successor to the fixed direct-mapped 64-set, 4-word cache. Adds associativity, a ready/valid CPU handshake, and hit/miss counters.

Parameters:
NUM_SETS, 64, sets; power of two, >=2
NUM_WAYS, 2, ways per set; power of two, 1..8 (1 = direct-mapped)
WORDS_PER_LINE, 4, 32-bit words per line; power of two, >=2
ADDR_W, 32, byte address width
CNT_W, 16, width of the hit/miss counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  block can accept a request (high only in IDLE)
req_type  in  1  0 = read, 1 = write
address  in  ADDR_W  byte address; bits [1:0] ignored
data_in  in  32  CPU write word
dataOut  out  32  read data, valid while done_cache=1
done_cache  out  1  one-cycle completion pulse
hit  out  1  qualifies done_cache: 1 = request hit on lookup
mem_req_valid  out  1  memory request, held until mem_ready
mem_req_write  out  1  1 = write-back line, 0 = refill read
mem_addr  out  ADDR_W  line-aligned address (offset bits zero)
mem_wdata  out  32*WORDS_PER_LINE  victim line; word 0 in LSBs
mem_rdata  in  32*WORDS_PER_LINE  refill line; sampled when mem_ready=1 in REFILL
mem_ready  in  1  memory completes the current request
hit_count  out  CNT_W  saturating count of lookup hits
miss_count  out  CNT_W  saturating count of lookup misses

Behaviour:
- Address split: word = addr[OFS-1:2] with OFS = 2 + log2(WORDS_PER_LINE); index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Reset (rst=0, async): all valid and dirty bits cleared; round-robin pointers = 0; counters = 0; FSM = IDLE.
- Reset output values: req_ready=1, done_cache=0, hit=0, mem_req_valid=0, mem_req_write=0, mem_addr=0, dataOut=0.
- Data arrays are not reset.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: req_ready=1. On req_valid, register type/address/data and go to LOOKUP. Inputs are ignored in all other states.
- LOOKUP, hit (valid way with matching tag):
  - Read: dataOut = word. Write: update the word and set dirty.
  - done_cache=1, hit=1, hit_count++. Return to IDLE.
  - Hit latency: done_cache 1 cycle after acceptance.
- LOOKUP, miss:
  - miss_count++.
  - Victim = lowest-numbered invalid way; otherwise the set's round-robin pointer, which then increments modulo NUM_WAYS.
  - Victim valid and dirty -> WRITEBACK; otherwise -> REFILL.
- WRITEBACK: mem_req_valid=1, mem_req_write=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line, all held stable. On mem_ready -> REFILL.
- REFILL: mem_req_valid=1, mem_req_write=0, mem_addr = {req tag, index, 0}. On mem_ready: write line into the victim, tag = req tag, valid=1, dirty=0 -> RESPOND.
- RESPOND: perform the read/write on the filled line (a write sets dirty). done_cache=1, hit=0 -> IDLE.
- mem_req_valid drops the cycle after mem_ready is seen. mem_ready while mem_req_valid=0 is ignored.
- Counters saturate at all-ones with no wrap.
- Asynchronous reset mid-miss: outstanding memory transaction abandoned, mem_req_valid low immediately, all lines invalid.
- Simultaneous events: done_cache and req_ready are never both high. A new request is accepted no earlier than the cycle after done_cache.

Test Plan:
- Cold read 0x0000_1004 (defaults), memory returns line {0xD3,0xD2,0xD1,0xD0} -> one refill with mem_addr=0x0000_1000, no write-back; dataOut=0xD1, hit=0, miss_count=1.
- Repeat read 0x0000_1004 -> done_cache exactly 1 cycle after acceptance, hit=1, dataOut=0xD1, no mem_req_valid, hit_count=1.
- Write 0xCAFE_0000 to 0x0000_1008 (hit), then fill 0x2000 and 0x3000 (same index 0) -> third fill evicts way 0: WRITEBACK with mem_addr=0x1000, word 2 of mem_wdata=0xCAFE_0000, then REFILL 0x3000.
- Clean-victim miss (NUM_WAYS=1 build, reads 0x1000 then 0x2000) -> no WRITEBACK state, only one refill per miss.
- Hold mem_ready low 20 cycles in WRITEBACK -> mem_req_valid, mem_addr and mem_wdata stable throughout; req_ready=0; req_valid pulses ignored.
- Assert rst low during REFILL -> mem_req_valid=0 at once; after release, read of the prior hit address misses; counters=0.
